// File: rtl/pipearch_vector2scalar_pkg.sv
// Shared constants, state encoding and helpers for the pipearch vector/scalar blocks.
package pipearch_common;

    localparam int WORDS_PER_LINE = 16;
    localparam int WORD_SEL_W     = $clog2(WORDS_PER_LINE);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } v2s_state_t;

    // Lines needed to cover a word count, rounding a partial line up.
    function automatic logic [31-WORD_SEL_W:0] lines_for_words(input logic [31:0] words);
        return words[31:WORD_SEL_W] + {{(31-WORD_SEL_W){1'b0}}, |words[WORD_SEL_W-1:0]};
    endfunction

endpackage

// File: rtl/pipearch_vector2scalar_line_skid.sv
// Two-entry line buffer: 'cur' is the line being serialized, 'nxt' is the prefetched one.
module pipearch_line_skid
    import pipearch_common::*;
#(
    parameter int LINE_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [LINE_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  head_valid,
    output logic [LINE_WIDTH-1:0] head_data,
    output logic                  full
);

    logic                  cur_valid;
    logic                  nxt_valid;
    logic [LINE_WIDTH-1:0] cur;
    logic [LINE_WIDTH-1:0] nxt;

    // A push lands in 'cur' whenever 'cur' is (or is becoming) free with no prefetch waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_valid <= 1'b0;
            nxt_valid <= 1'b0;
            cur       <= '0;
            nxt       <= '0;
        end else if (pop && nxt_valid) begin
            cur       <= nxt;
            nxt_valid <= push;
            if (push) begin
                nxt <= push_data;
            end
        end else if (pop) begin
            cur_valid <= push;
            if (push) begin
                cur <= push_data;
            end
        end else if (push) begin
            if (!cur_valid) begin
                cur       <= push_data;
                cur_valid <= 1'b1;
            end else begin
                nxt       <= push_data;
                nxt_valid <= 1'b1;
            end
        end
    end

    assign head_valid = cur_valid;
    assign head_data  = cur;
    assign full       = nxt_valid;

endmodule

// File: rtl/pipearch_vector2scalar.sv
// Serializes wide cache lines into a stream of scalars for a bounded job,
// then pulses flush so the downstream packer can emit its partial line.
module pipearch_vector2scalar
    import pipearch_common::*;
#(
    parameter int LINE_WIDTH = 512,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [31:0]           total_words,
    input  logic                  in_valid,
    input  logic [LINE_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [WORD_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  flush,
    output logic                  done,
    output logic                  busy
);

    localparam int WORDS = LINE_WIDTH / WORD_WIDTH;
    localparam int IDX_W = $clog2(WORDS);

    v2s_state_t            state;
    logic [IDX_W-1:0]      idx;
    logic [31:0]           remaining;
    logic [27:0]           lines_left;

    logic                  cur_valid;
    logic                  nxt_valid;
    logic [LINE_WIDTH-1:0] cur_line;
    logic                  take_line;
    logic                  take_word;
    logic                  last_word;
    logic                  retire;

    assign out_valid = (state == RUN) && cur_valid;
    assign out_data  = cur_line[32'(idx) * WORD_WIDTH +: WORD_WIDTH];
    assign take_word = out_valid && out_ready;
    assign last_word = (remaining == 32'd1);
    assign retire    = take_word && ((idx == IDX_W'(WORDS - 1)) || last_word);

    // Only registered state plus out_ready feed in_ready, so upstream never sees a loop through in_valid.
    assign in_ready  = (state == RUN) && (lines_left != '0) && (!nxt_valid || retire);
    assign take_line = in_valid && in_ready;
    assign busy      = (state != IDLE);

    pipearch_line_skid #(
        .LINE_WIDTH (LINE_WIDTH)
    ) u_skid (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (take_line),
        .push_data  (in_data),
        .pop        (retire),
        .head_valid (cur_valid),
        .head_data  (cur_line),
        .full       (nxt_valid)
    );

    // Job sequencing; flush and done are registered one-cycle pulses tied to entering FLUSH/DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            remaining  <= '0;
            lines_left <= '0;
            flush      <= 1'b0;
            done       <= 1'b0;
        end else begin
            flush <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining  <= total_words;
                        lines_left <= lines_for_words(total_words);
                        idx        <= '0;
                        if (total_words == 32'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (take_line) begin
                        lines_left <= lines_left - 28'd1;
                    end
                    if (take_word) begin
                        remaining <= remaining - 32'd1;
                        idx       <= retire ? '0 : idx + IDX_W'(1);
                        if (last_word) begin
                            state <= FLUSH;
                            flush <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipearch_vector2scalar.sv
// Directed bench: per-cycle vector table for clean jobs, plus hand sequences for stalls,
// mid-job reset and start-while-busy.
module tb_pipearch_vector2scalar;

    typedef struct {
        logic        start;
        logic [31:0] tw;
        logic        in_valid;
        logic [31:0] line_base;
        logic        out_ready;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic [31:0] exp_out_data;
        logic        exp_flush;
        logic        exp_done;
        logic        exp_busy;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [31:0]  total_words;
    logic         in_valid;
    logic [511:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_ready;
    logic         flush;
    logic         done;
    logic         busy;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pipearch_vector2scalar dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .total_words (total_words),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .flush       (flush),
        .done        (done),
        .busy        (busy)
    );

    function automatic logic [511:0] make_line(input logic [31:0] base);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) begin
            l[k*32 +: 32] = base + 32'(k);
        end
        return l;
    endfunction

    function automatic vec_t row(input logic st, input logic [31:0] tw, input logic iv,
                                 input logic [31:0] base, input logic ir, input logic ov,
                                 input logic [31:0] d, input logic fl, input logic dn,
                                 input logic bz);
        vec_t v;
        v.start = st; v.tw = tw; v.in_valid = iv; v.line_base = base; v.out_ready = 1'b1;
        v.exp_in_ready = ir; v.exp_out_valid = ov; v.exp_out_data = d;
        v.exp_flush = fl; v.exp_done = dn; v.exp_busy = bz;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Two-line job with out_ready held high; lines offered back-to-back, a spare third line stays offered.
    task automatic add_job(input logic [31:0] tag, input int tw);
        vecs.push_back(row(1, 32'(tw), 0, 0,        0, 0, 0,   0, 0, 0));
        vecs.push_back(row(0, 0,       1, tag,      1, 0, 0,   0, 0, 1));
        vecs.push_back(row(0, 0,       1, tag + 16, 1, 1, tag, 0, 0, 1));
        for (int k = 1; k < tw; k++) begin
            vecs.push_back(row(0, 0, 1, tag + 32, 0, 1, tag + 32'(k), 0, 0, 1));
        end
        vecs.push_back(row(0, 0, 1, tag + 32, 0, 0, 0, 1, 0, 1));
        vecs.push_back(row(0, 0, 0, 0,        0, 0, 0, 0, 1, 1));
        vecs.push_back(row(0, 0, 0, 0,        0, 0, 0, 0, 0, 0));
    endtask

    task automatic apply_stimulus(input vec_t v);
        start       = v.start;
        total_words = v.tw;
        in_valid    = v.in_valid;
        in_data     = make_line(v.line_base);
        out_ready   = v.out_ready;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " in_ready"},  32'(in_ready),  0);
        check_output({tag, " out_valid"}, 32'(out_valid), 0);
        check_output({tag, " out_data"},  out_data,       0);
        check_output({tag, " flush"},     32'(flush),     0);
        check_output({tag, " done"},      32'(done),      0);
        check_output({tag, " busy"},      32'(busy),      0);
    endtask

    // Runs a job with out_ready=1 and lines always offered; optionally pokes start mid-job.
    task automatic run_job(input string name, input logic [31:0] tag, input int tw, input logic poke);
        int k;
        int acc;
        k   = 0;
        acc = 0;
        start = 1'b1; total_words = 32'(tw); in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = poke;
        total_words = poke ? 32'd5 : 32'(tw);
        for (int cyc = 0; cyc < 200 && k < tw; cyc++) begin
            in_valid = 1'b1;
            in_data  = make_line(tag + 32'(acc * 16));
            #1;
            if (out_valid) begin
                check_output({name, " out_data"}, out_data, tag + 32'(k));
                k++;
            end
            if (in_ready) acc++;
            @(negedge clk);
        end
        check_output({name, " word count"}, 32'(k), 32'(tw));
        start = 1'b0;
        #1;
        check_output({name, " flush"},    32'(flush),    1);
        check_output({name, " in_ready"}, 32'(in_ready), 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_output({name, " done"}, 32'(done), 1);
        check_output({name, " lines accepted"}, 32'(acc), 32'((tw + 15) / 16));
        @(negedge clk);
        #1;
        check_output({name, " idle busy"}, 32'(busy), 0);
    endtask

    initial begin
        int acc_tbl;
        int acc;
        int ret;
        int k;
        logic running;
        logic prev_stall;
        logic exp_ov;
        logic exp_ir;
        logic retiring;
        logic [3:0] pat;
        logic [31:0] stag;

        reset_n = 1'b0; start = 1'b0; total_words = '0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        add_job(32'h0000_0000, 32);
        add_job(32'h0000_1000, 20);
        vecs.push_back(row(1, 0, 1, 32'h0000_1100, 0, 0, 0, 0, 0, 0));
        vecs.push_back(row(0, 0, 1, 32'h0000_1100, 0, 0, 0, 0, 1, 1));
        vecs.push_back(row(0, 0, 0, 0,             0, 0, 0, 0, 0, 0));

        acc_tbl = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            #1;
            check_output($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(vecs[i].exp_in_ready));
            check_output($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_out_valid));
            if (vecs[i].exp_out_valid)
                check_output($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_out_data);
            check_output($sformatf("vec%0d flush", i), 32'(flush), 32'(vecs[i].exp_flush));
            check_output($sformatf("vec%0d done", i),  32'(done),  32'(vecs[i].exp_done));
            check_output($sformatf("vec%0d busy", i),  32'(busy),  32'(vecs[i].exp_busy));
            if (in_valid && in_ready) acc_tbl++;
            @(negedge clk);
        end
        check_output("table lines accepted", 32'(acc_tbl), 4);

        // Stalled 48-word job: out_ready follows 1,0,0,1 so both line slots fill up.
        stag = 32'h0000_2000;
        pat  = 4'b1001;
        start = 1'b1; total_words = 32'd48; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        acc = 0; ret = 0; k = 0; running = 1'b1; prev_stall = 1'b0;
        for (int cyc = 0; cyc < 400 && running; cyc++) begin
            out_ready = pat[cyc % 4];
            in_valid  = (acc < 3);
            in_data   = make_line(stag + 32'(acc * 16));
            #1;
            exp_ov   = (acc - ret) > 0;
            retiring = exp_ov && out_ready && ((k % 16 == 15) || (k == 47));
            exp_ir   = (acc < 3) && (((acc - ret) < 2) || retiring);
            if (prev_stall)
                check_output("stall hold out_valid", 32'(out_valid), 1);
            check_output("stall out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov)
                check_output("stall out_data", out_data, stag + 32'(k));
            check_output("stall in_ready", 32'(in_ready), 32'(exp_ir));
            if (exp_ov && out_ready) begin
                if (retiring) ret++;
                k++;
                if (k == 48) running = 1'b0;
            end
            if (in_valid && exp_ir) acc++;
            prev_stall = exp_ov && !out_ready;
            @(negedge clk);
        end
        check_output("stall words emitted", 32'(k), 48);
        in_valid = 1'b0;
        #1;
        check_output("stall flush", 32'(flush), 1);
        check_output("stall out_valid after last", 32'(out_valid), 0);
        @(negedge clk);
        #1;
        check_output("stall done", 32'(done), 1);
        check_output("stall flush pulse", 32'(flush), 0);
        @(negedge clk);

        // Reset pulled while word 7 of a 16-word line is presented.
        start = 1'b1; total_words = 32'd16; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = make_line(32'h0000_3000);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (7) @(negedge clk);
        #1;
        check_output("pre-reset out_data", out_data, 32'h0000_3007);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid-job reset");
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b0;
        #1;
        check_all_zero("post-reset");
        run_job("after reset", 32'h0000_4000, 16, 1'b0);

        run_job("start in RUN", 32'h0000_5000, 20, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
